if_fetch_ctrl: RTL and testbench

- Fetch sequencer for the IF stage.
- Owns the program counter and issues word-aligned read requests to the fixed-latency instruction memory.
- Tracks requests in flight and buffers returned instructions with their PC in a small FIFO, presented to decode over a valid/ready handshake.
- Branch/jump redirects from EX flush all in-flight and buffered fetches.

---
 rtl/if_fetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, tracks fixed-latency memory reads, buffers results for decode.
// Optional performance counters are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic [31:0] i_mem_instr,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
`ifdef IF_FETCH_PERF_EN
   output logic [31:0] o_perf_fetched,
   output logic [31:0] o_perf_stall,
   output logic [31:0] o_perf_flushed,
`endif
   output logic [2:0]  o_inflight
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = CW + 3;

   logic [31:0]        pc_q, pc_d;
   logic [MEM_LAT-1:0] trk_vld_q, trk_vld_d;
   logic [31:0]        trk_pc_q [MEM_LAT];
   logic [31:0]        trk_pc_d [MEM_LAT];
   logic [2:0]         inflight_q, inflight_d;
   logic [31:0]        fifo_instr_q [FIFO_DEPTH];
   logic [31:0]        fifo_pc_q    [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d, remain;
   logic               valid_q, valid_d;
   logic [31:0]        instr_q, instr_d, hpc_q, hpc_d;
   logic               pop, push, issue;
   logic [SW-1:0]      occ;
   logic [31:0]        rsp_pc;

   // Buffered plus outstanding entries never exceed the FIFO, so a landing response always fits.
   assign pop    = valid_q && i_ready;
   assign occ    = SW'(count_q) + SW'(inflight_q) - SW'(pop);
   assign issue  = i_rst_n && i_en && !i_redirect && (occ < SW'(FIFO_DEPTH));
   assign rsp_pc = trk_pc_q[MEM_LAT-1];
   assign push   = trk_vld_q[MEM_LAT-1] && !i_redirect;
   assign remain = count_q - CW'(pop);

   assign o_mem_req  = issue;
   assign o_mem_addr = pc_q;
   assign o_valid    = valid_q;
   assign o_instr    = instr_q;
   assign o_pc       = hpc_q;
   assign o_inflight = inflight_q;

   // Next-state for PC, tracking pipe, FIFO pointers and the registered head.
   always_comb begin
      pc_d       = pc_q;
      trk_vld_d  = '0;
      inflight_d = '0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      valid_d    = valid_q;
      instr_d    = instr_q;
      hpc_d      = hpc_q;
      for (int i = 0; i < int'(MEM_LAT); i++) trk_pc_d[i] = '0;

      trk_vld_d[0] = issue;
      trk_pc_d[0]  = pc_q;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
         trk_vld_d[i] = trk_vld_q[i-1];
         trk_pc_d[i]  = trk_pc_q[i-1];
      end

      if (i_redirect) begin
         pc_d      = {i_redirect_pc[31:2], 2'b00};
         trk_vld_d = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         valid_d   = 1'b0;
      end else begin
         if (issue) pc_d = pc_q + 32'd4;
         if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
         valid_d = (count_d != '0);
         if (count_d != '0) begin
            if (remain == '0) begin
               instr_d = i_mem_instr;
               hpc_d   = rsp_pc;
            end else begin
               instr_d = fifo_instr_q[rd_ptr_d];
               hpc_d   = fifo_pc_q[rd_ptr_d];
            end
         end
      end

      for (int i = 0; i < int'(MEM_LAT); i++) inflight_d = inflight_d + 3'(trk_vld_d[i]);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q       <= RESET_PC;
         trk_vld_q  <= '0;
         for (int i = 0; i < int'(MEM_LAT); i++) trk_pc_q[i] <= '0;
         inflight_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         instr_q    <= '0;
         hpc_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         trk_vld_q  <= trk_vld_d;
         trk_pc_q   <= trk_pc_d;
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         hpc_q      <= hpc_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by count/pointers.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_instr_q[wr_ptr_q] <= i_mem_instr;
         fifo_pc_q[wr_ptr_q]    <= rsp_pc;
      end
   end

`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_stall_q, perf_flushed_q;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
         perf_flushed_q <= '0;
      end else begin
         if (push) perf_fetched_q <= sat_add(perf_fetched_q, 32'd1);
         if (i_en && !i_redirect && !issue) perf_stall_q <= sat_add(perf_stall_q, 32'd1);
         if (i_redirect)
            perf_flushed_q <= sat_add(perf_flushed_q, 32'(inflight_q) + 32'(count_q));
      end
   end

   assign o_perf_fetched = perf_fetched_q;
   assign o_perf_stall   = perf_stall_q;
   assign o_perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl (MEM_LAT=1, FIFO_DEPTH=2) with a one-cycle memory model.
module tb_if_fetch_ctrl;

   logic        i_clk, i_rst_n, i_en, i_redirect, i_ready;
   logic [31:0] i_redirect_pc, i_mem_instr;
   logic        o_mem_req, o_valid;
   logic [31:0] o_mem_addr, o_instr, o_pc;
   logic [2:0]  o_inflight;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] o_perf_fetched, o_perf_stall, o_perf_flushed;
`endif

   int n_vec = 0;
   int n_err = 0;

   if_fetch_ctrl #(.RESET_PC(32'h0), .MEM_LAT(1), .FIFO_DEPTH(2)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_redirect(i_redirect),
      .i_redirect_pc(i_redirect_pc), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
      .i_mem_instr(i_mem_instr), .o_valid(o_valid), .i_ready(i_ready),
      .o_instr(o_instr), .o_pc(o_pc),
`ifdef IF_FETCH_PERF_EN
      .o_perf_fetched(o_perf_fetched), .o_perf_stall(o_perf_stall),
      .o_perf_flushed(o_perf_flushed),
`endif
      .o_inflight(o_inflight));

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] f(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory answers one cycle after a request; unrequested cycles return junk.
   always @(posedge i_clk)
      i_mem_instr <= o_mem_req ? f(o_mem_addr) : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge i_clk);
   endtask

   initial begin
      i_rst_n = 1'b0; i_en = 1'b1; i_ready = 1'b1; i_redirect = 1'b0;
      i_redirect_pc = '0;
      step(); #1;
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_req", 32'(o_mem_req), 0);
      chk("rst_instr", o_instr, 0);
      chk("rst_pc", o_pc, 0);
      chk("rst_inflight", 32'(o_inflight), 0);
      chk("rst_addr", o_mem_addr, 0);
`ifdef IF_FETCH_PERF_EN
      chk("rst_perf", o_perf_fetched, 0);
`endif

      // Streaming from reset
      i_rst_n = 1'b1; #1;
      chk("s1_c0_req", 32'(o_mem_req), 1);
      chk("s1_c0_addr", o_mem_addr, 0);
      chk("s1_c0_valid", 32'(o_valid), 0);
      step(); #1;
      chk("s1_c1_addr", o_mem_addr, 4);
      chk("s1_c1_inflight", 32'(o_inflight), 1);
      chk("s1_c1_valid", 32'(o_valid), 0);
      for (int k = 2; k < 8; k++) begin
         step(); #1;
         chk("s1_valid", 32'(o_valid), 1);
         chk("s1_pc", o_pc, 32'(4 * (k - 2)));
         chk("s1_instr", o_instr, f(32'(4 * (k - 2))));
         chk("s1_addr", o_mem_addr, 32'(4 * k));
      end
`ifdef IF_FETCH_PERF_EN
      chk("s1_perf_fetched", o_perf_fetched, 6);
`endif

      // Backpressure fills the FIFO, then drains
      step(); i_rst_n = 1'b0; i_ready = 1'b0; #1;
      step(); i_rst_n = 1'b1; #1;
      chk("s2_c0_addr", o_mem_addr, 0);
      step(); #1;
      chk("s2_c1_req", 32'(o_mem_req), 1);
      step(); #1;
      chk("s2_c2_req", 32'(o_mem_req), 0);
      chk("s2_c2_pc", o_pc, 0);
      step(); #1;
      chk("s2_c3_req", 32'(o_mem_req), 0);
      chk("s2_c3_inflight", 32'(o_inflight), 0);
      chk("s2_c3_valid", 32'(o_valid), 1);
      chk("s2_c3_addr", o_mem_addr, 8);
      step(); i_ready = 1'b1; #1;
      chk("s2_c4_req", 32'(o_mem_req), 1);
      chk("s2_c4_pc", o_pc, 0);
      step(); #1;
      chk("s2_c5_pc", o_pc, 4);
      chk("s2_c5_addr", o_mem_addr, 12);

      // Redirect with one buffered and one in flight; misaligned target
      step(); i_ready = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h16; #1;
      chk("s3_c6_pc", o_pc, 8);
      chk("s3_c6_inflight", 32'(o_inflight), 1);
      chk("s3_c6_req", 32'(o_mem_req), 0);
      step(); i_redirect = 1'b0; i_ready = 1'b1; #1;
      chk("s3_c7_valid", 32'(o_valid), 0);
      chk("s3_c7_inflight", 32'(o_inflight), 0);
      chk("s3_c7_addr", o_mem_addr, 32'h14);
      chk("s3_c7_hold_pc", o_pc, 8);
      step(); #1;
      chk("s3_c8_valid", 32'(o_valid), 0);
      chk("s3_c8_addr", o_mem_addr, 32'h18);

      // Redirect coincident with pop and response sampling
      step(); i_redirect = 1'b1; i_redirect_pc = 32'h100; #1;
      chk("s4_c9_valid", 32'(o_valid), 1);
      chk("s4_c9_pc", o_pc, 32'h14);
      chk("s4_c9_instr", o_instr, f(32'h14));
      chk("s4_c9_inflight", 32'(o_inflight), 1);
      step(); i_redirect = 1'b0; #1;
      chk("s4_c10_valid", 32'(o_valid), 0);
      chk("s4_c10_inflight", 32'(o_inflight), 0);
      chk("s4_c10_addr", o_mem_addr, 32'h100);
      chk("s4_c10_hold_pc", o_pc, 32'h14);
      step(); #1;
      chk("s4_c11_valid", 32'(o_valid), 0);

      // PC wrap, then fetch disable drains
      step(); i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFE; #1;
      chk("s6_c12_pc", o_pc, 32'h100);
      step(); i_redirect = 1'b0; #1;
      chk("s6_c13_addr", o_mem_addr, 32'hFFFF_FFFC);
      chk("s6_c13_req", 32'(o_mem_req), 1);
      step(); #1;
      chk("s6_c14_addr", o_mem_addr, 0);
      step(); i_en = 1'b0; #1;
      chk("s6_c15_pc", o_pc, 32'hFFFF_FFFC);
      chk("s6_c15_instr", o_instr, f(32'hFFFF_FFFC));
      chk("s6_c15_req", 32'(o_mem_req), 0);
      chk("s6_c15_addr", o_mem_addr, 4);
      step(); #1;
      chk("s6_c16_pc", o_pc, 0);
      chk("s6_c16_valid", 32'(o_valid), 1);
      chk("s6_c16_inflight", 32'(o_inflight), 0);
      step(); #1;
      chk("s6_c17_valid", 32'(o_valid), 0);
      chk("s6_c17_hold_pc", o_pc, 0);

      // Reset pulsed mid-stream at pc=40
      step(); i_en = 1'b1; i_rst_n = 1'b0; #1;
      step(); i_rst_n = 1'b1; #1;
      for (int k = 1; k < 11; k++) begin
         step(); #1;
      end
      chk("s5_addr40", o_mem_addr, 40);
      chk("s5_pc32", o_pc, 32);
      i_rst_n = 1'b0; #1;
      chk("s5_rst_valid", 32'(o_valid), 0);
      chk("s5_rst_req", 32'(o_mem_req), 0);
      chk("s5_rst_addr", o_mem_addr, 0);
      chk("s5_rst_inflight", 32'(o_inflight), 0);
      step(); i_rst_n = 1'b1; #1;
      chk("s5_c0_addr", o_mem_addr, 0);
      chk("s5_c0_req", 32'(o_mem_req), 1);
      step(); #1;
      chk("s5_c1_valid", 32'(o_valid), 0);
      step(); #1;
      chk("s5_c2_valid", 32'(o_valid), 1);
      chk("s5_c2_pc", o_pc, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
